// File: rtl/single_port_bram.sv
// rtl/single_port_bram.sv - single-port block RAM, read-first, registered output
module single_port_bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Declaration initialiser gives the all-zero power-up image without touching reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_data_out;

    // Kept free of any reset term so the array maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            r_mem[addr] <= data_in;
        end
    end

    // Non-blocking read of r_mem returns the pre-write word: read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= r_mem[addr];
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_single_port_bram.sv
// tb/tb_single_port_bram.sv - directed self-checking bench for single_port_bram
module tb_single_port_bram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_a;
    logic [7:0]  addr_a;
    logic [7:0]  din_a;
    logic [7:0]  dout_a;
    logic        we_b;
    logic [3:0]  addr_b;
    logic [15:0] din_b;
    logic [15:0] dout_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    single_port_bram u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_a),
        .addr     (addr_a),
        .data_in  (din_a),
        .data_out (dout_a)
    );

    single_port_bram #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut_w16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_b),
        .addr     (addr_b),
        .data_in  (din_b),
        .data_out (dout_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        we_a   = 1'b0;
        addr_a = 8'h5A;
        din_a  = 8'h00;
        we_b   = 1'b0;
        addr_b = 4'h3;
        din_b  = 16'h0000;
        #1;
        check("reset_async_a", {8'h00, dout_a}, 16'h0000);
        repeat (3) step();
        check("reset_hold_a", {8'h00, dout_a}, 16'h0000);
        check("reset_hold_b", dout_b, 16'h0000);

        rst_n  = 1'b1;
        addr_a = 8'h00;
        addr_b = 4'h0;
        step();
        check("init_read_addr0_a", {8'h00, dout_a}, 16'h0000);
        check("init_read_addr0_b", dout_b, 16'h0000);

        we_a = 1'b1;
        for (int i = 1; i < 256; i++) begin
            addr_a = 8'(i);
            din_a  = 8'(i);
            step();
        end
        we_a = 1'b0;
        for (int i = 1; i < 256; i++) begin
            addr_a = 8'(i);
            step();
            check($sformatf("fill_read_%0d", i), {8'h00, dout_a}, 16'(i));
        end

        addr_a = 8'h10;
        din_a  = 8'hAB;
        we_a   = 1'b1;
        step();
        check("read_first_old", {8'h00, dout_a}, 16'h0010);
        we_a = 1'b0;
        step();
        check("read_first_new", {8'h00, dout_a}, 16'h00AB);

        addr_a = 8'h20;
        step();
        check("pre_reset_read", {8'h00, dout_a}, 16'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", {8'h00, dout_a}, 16'h0000);
        @(negedge clk);
        we_a  = 1'b1;
        din_a = 8'h55;
        step();
        step();
        check("mid_reset_hold", {8'h00, dout_a}, 16'h0000);
        we_a  = 1'b0;
        rst_n = 1'b1;
        check("release_no_edge", {8'h00, dout_a}, 16'h0000);
        step();
        check("write_suppressed", {8'h00, dout_a}, 16'h0020);
        addr_a = 8'h10;
        step();
        check("mem_kept_reset", {8'h00, dout_a}, 16'h00AB);

        we_a   = 1'b1;
        addr_a = 8'hFF;
        din_a  = 8'hFF;
        step();
        addr_a = 8'h00;
        din_a  = 8'h01;
        step();
        we_a   = 1'b0;
        addr_a = 8'hFF;
        step();
        check("boundary_ff", {8'h00, dout_a}, 16'h00FF);
        addr_a = 8'h00;
        step();
        check("boundary_00", {8'h00, dout_a}, 16'h0001);
        addr_a = 8'h7F;
        step();
        check("mid_untouched", {8'h00, dout_a}, 16'h007F);

        we_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_b = 4'(i);
            din_b  = 16'hA500 | 16'(i);
            step();
        end
        we_b = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            addr_b = 4'(i);
            step();
            check($sformatf("w16_read_%0d", i), dout_b, 16'hA500 | 16'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
